// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDW      = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector (highest set bit if several).
  // The input is 32 bits wide, so this supports up to 32 requesters.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority winner selection: the first set request at or above ptr,
// otherwise the first set request from bit 0. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = ARB_IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] win_idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_vec;
  logic [N-1:0] lowest;

  assign mask     = ~((N'(1) << ptr) - N'(1));
  assign masked   = req & mask;
  assign pick_vec = (|masked) ? masked : req;
  // Isolate the lowest set bit, then convert it to a binary index.
  assign lowest   = pick_vec & (~pick_vec + N'(1));
  assign win_idx  = IDW'(onehot_to_idx(32'(lowest)));
  assign any      = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registers a one-hot grant plus index for one owner,
// held until done, request drop, disable or MAX_HOLD expiry, followed by a
// one-cycle turnaround gap.
//
//  state | meaning
//  IDLE  | no owner; grant to rotating-priority winner when en && |req
//  BUSY  | owner holds gnt; hold_cnt counts cycles held from 1
//  GAP   | one-cycle resource turnaround after a release
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = ARB_IDW,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           timeout
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  arb_state_e     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           gnt_vld_nxt;
  logic           timeout_nxt;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           hold_max;
  logic           release_now;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  assign hold_max    = (hold_cnt == HCW'(MAX_HOLD));
  // Any release cause collapses into a single release.
  assign release_now = done || !req[gnt_id] || !en || hold_max;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && pick_any) state_nxt = BUSY;
      BUSY:    if (release_now)    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the grant outputs, rotation pointer and hold counter.
  always_comb begin
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    gnt_vld_nxt  = gnt_vld;
    timeout_nxt  = 1'b0;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (en && pick_any) begin
          gnt_nxt      = N'(1) << pick_idx;
          gnt_id_nxt   = pick_idx;
          gnt_vld_nxt  = 1'b1;
          hold_cnt_nxt = HCW'(1);
        end
      end
      BUSY: begin
        if (release_now) begin
          gnt_nxt      = '0;
          gnt_vld_nxt  = 1'b0;
          timeout_nxt  = hold_max;
          ptr_nxt      = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nxt     = '0;
        gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      gnt_vld  <= gnt_vld_nxt;
      timeout  <= timeout_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule
